wishbone_2mst_arbiter: RTL and testbench

WISHBONE_2MST_ARBITER -- requirements
Module: wishbone_2mst_arbiter

---
 rtl/wishbone_2mst_arbiter.sv | 90 +++++++++
 tb/tb_wishbone_2mst_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_2mst_arbiter.sv
// wishbone_2mst_arbiter: round-robin two-master Wishbone arbiter with slave-stall timeout
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; m0_*/m1_* master buses;
//        s_* shared slave bus; to_irq one-cycle timeout pulse; grant_o one-hot owner.
module wishbone_2mst_arbiter #(
    parameter int TO_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic        to_irq,
    output logic [1:0]  grant_o
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    localparam logic [31:0] TO_DATA = 32'hBADC0DE0;
    state_t state_q, state_d;
    logic last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic g0, g1, req0, req1, own_cyc, own_stb, timeout;
    assign g0 = state_q == GNT0;
    assign g1 = state_q == GNT1;
    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign own_cyc = g1 ? m1_cyc_i : g0 & m0_cyc_i;
    assign own_stb = g1 ? m1_stb_i : g0 & m0_stb_i;
    // a real ack in the same cycle as the limit suppresses the timeout
    assign timeout = own_cyc & own_stb & ~s_ack_i & (cnt_q == 16'(TO_CYCLES));
    always_comb begin
        state_d = state_q;
        last_d = last_q;
        cnt_d = 16'd0;
        if (state_q == IDLE) begin
            // last_q = 1 means master 1 was granted last, so master 0 wins a tie
            if (req0 & (~req1 | last_q))
                state_d = GNT0;
            else if (req1)
                state_d = GNT1;
        end else if (!own_cyc) begin
            state_d = IDLE;
            last_d = g1;
        end else if (own_stb & ~s_ack_i & ~timeout) begin
            cnt_d = cnt_q + 16'd1;
        end
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q <= 1'b1;
            cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
        end
    end
    assign s_cyc_o = own_cyc & ~timeout;
    assign s_stb_o = own_stb & ~timeout;
    assign s_we_o = g1 ? m1_we_i : g0 & m0_we_i;
    assign s_sel_o = g1 ? m1_sel_i : g0 ? m0_sel_i : 4'd0;
    assign s_adr_o = g1 ? m1_adr_i : g0 ? m0_adr_i : 32'd0;
    assign s_dat_o = g1 ? m1_dat_i : g0 ? m0_dat_i : 32'd0;
    assign m0_ack_o = g0 & (s_ack_i | timeout);
    assign m1_ack_o = g1 & (s_ack_i | timeout);
    assign m0_dat_o = !g0 ? 32'd0 : timeout ? TO_DATA : s_dat_i;
    assign m1_dat_o = !g1 ? 32'd0 : timeout ? TO_DATA : s_dat_i;
    assign to_irq = timeout;
    assign grant_o = {g1, g0};
endmodule

// File: tb/tb_wishbone_2mst_arbiter.sv
// tb_wishbone_2mst_arbiter: directed and random checks of the arbiter against a cycle model
module tb_wishbone_2mst_arbiter;
    localparam int TO = 8;
    localparam logic [31:0] BAD = 32'hBADC0DE0;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mc [2];
    logic ms [2];
    logic mw [2];
    logic [3:0] msel [2];
    logic [31:0] madr [2];
    logic [31:0] mdat [2];
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic m0_ack_o, m1_ack_o, s_cyc_o, s_stb_o, s_we_o, to_irq;
    logic [3:0] s_sel_o;
    logic [1:0] grant_o;
    logic [31:0] s_dat = 32'd0;
    logic s_ack = 1'b0;
    int checks = 0;
    int errors = 0;
    int owner = -1;
    int last = 1;
    int stall = 0;
    int n_irq = 0;
    int irq0;
    int ackw;

    always #5 clk = ~clk;

    wishbone_2mst_arbiter #(.TO_CYCLES(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_sel_i(msel[0]),
        .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_sel_i(msel[1]),
        .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
        .to_irq(to_irq), .grant_o(grant_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
        mc[i] = c;
        ms[i] = s;
        mw[i] = w;
        msel[i] = 4'hF;
        madr[i] = a;
        mdat[i] = d;
    endtask

    task automatic model_reset();
        owner = -1;
        last = 1;
        stall = 0;
    endtask

    // one clock: check outputs mid-cycle against the model, then advance the model at the edge
    task automatic step();
        logic tout, ec, es, ew, r0, r1;
        logic [3:0] esel;
        logic [31:0] ea, ed;
        int x;
        @(negedge clk);
        x = owner;
        tout = 1'b0;
        ec = 1'b0;
        es = 1'b0;
        ew = 1'b0;
        esel = 4'd0;
        ea = 32'd0;
        ed = 32'd0;
        if (x >= 0) begin
            tout = mc[x] && ms[x] && !s_ack && stall == TO;
            ec = mc[x] && !tout;
            es = ms[x] && !tout;
            ew = mw[x];
            esel = msel[x];
            ea = madr[x];
            ed = mdat[x];
        end
        chk("grant", 32'(grant_o), x < 0 ? 32'd0 : x == 0 ? 32'd1 : 32'd2);
        chk("s_cyc", 32'(s_cyc_o), 32'(ec));
        chk("s_stb", 32'(s_stb_o), 32'(es));
        chk("s_we", 32'(s_we_o), 32'(ew));
        chk("s_sel", 32'(s_sel_o), 32'(esel));
        chk("s_adr", s_adr_o, ea);
        chk("s_dat", s_dat_o, ed);
        chk("to_irq", 32'(to_irq), 32'(tout));
        chk("m0_ack", 32'(m0_ack_o), 32'(x == 0 && (s_ack || tout)));
        chk("m1_ack", 32'(m1_ack_o), 32'(x == 1 && (s_ack || tout)));
        chk("m0_dat", m0_dat_o, x != 0 ? 32'd0 : tout ? BAD : s_dat);
        chk("m1_dat", m1_dat_o, x != 1 ? 32'd0 : tout ? BAD : s_dat);
        if (tout) n_irq++;
        r0 = mc[0] && ms[0];
        r1 = mc[1] && ms[1];
        @(posedge clk);
        if (rst) model_reset();
        else if (owner < 0) begin
            stall = 0;
            if (r0 && r1) owner = last == 1 ? 0 : 1;
            else if (r0) owner = 0;
            else if (r1) owner = 1;
        end else if (!mc[owner]) begin
            last = owner;
            owner = -1;
            stall = 0;
        end else if (!ms[owner] || s_ack || tout) stall = 0;
        else stall++;
        #1;
    endtask

    initial begin
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        #2;
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_cyc", 32'(s_cyc_o), 32'd0);
        chk("rst_irq", 32'(to_irq), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        // single master write, slave acks two cycles after grant
        set_m(0, 1, 1, 1, 32'h30010004, 32'h12345678);
        step();
        chk("w_grant", 32'(grant_o), 32'd1);
        chk("w_adr", s_adr_o, 32'h30010004);
        chk("w_dat", s_dat_o, 32'h12345678);
        step();
        step();
        s_ack = 1'b1;
        #1;
        chk("w_ack", 32'(m0_ack_o), 32'd1);
        chk("w_m1ack", 32'(m1_ack_o), 32'd0);
        step();
        s_ack = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        step();
        step();
        // simultaneous requests from reset: round-robin
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
        set_m(0, 1, 1, 0, 32'h100, 32'h0);
        set_m(1, 1, 1, 0, 32'h200, 32'h0);
        step();
        chk("rr_first", 32'(grant_o), 32'd1);
        s_ack = 1'b1;
        s_dat = 32'h0000AAAA;
        step();
        s_ack = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        step();
        chk("rr_idle", 32'(grant_o), 32'd0);
        set_m(0, 1, 1, 0, 32'h104, 32'h0);
        step();
        chk("rr_second", 32'(grant_o), 32'd2);
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        set_m(1, 0, 0, 0, 0, 0);
        step();
        chk("rr_idle2", 32'(grant_o), 32'd0);
        step();
        chk("rr_third", 32'(grant_o), 32'd1);
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        step();
        step();
        // locked burst by master 1 is not preempted
        set_m(1, 1, 1, 1, 32'h40000000, 32'h55AA55AA);
        step();
        chk("burst_grant", 32'(grant_o), 32'd2);
        set_m(0, 1, 1, 0, 32'h300, 32'h0);
        for (int k = 0; k < 4; k++) begin
            madr[1] = 32'h40000000 + 32'(k * 4);
            step();
            s_ack = 1'b1;
            step();
            s_ack = 1'b0;
            chk("burst_hold", 32'(grant_o), 32'd2);
        end
        set_m(1, 0, 0, 0, 0, 0);
        step();
        chk("burst_idle", 32'(grant_o), 32'd0);
        step();
        chk("burst_m0", 32'(grant_o), 32'd1);
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        step();
        step();
        // timeout: slave never acks a master 0 read
        set_m(0, 1, 1, 0, 32'h500, 32'h0);
        irq0 = n_irq;
        step();
        for (int k = 0; k < TO; k++) step();
        chk("to_ack", 32'(m0_ack_o), 32'd1);
        chk("to_dat", m0_dat_o, BAD);
        chk("to_irq_hi", 32'(to_irq), 32'd1);
        chk("to_stb", 32'(s_stb_o), 32'd0);
        step();
        chk("to_count", 32'(n_irq - irq0), 32'd1);
        chk("to_grant", 32'(grant_o), 32'd1);
        chk("to_irq_lo", 32'(to_irq), 32'd0);
        set_m(0, 0, 0, 0, 0, 0);
        step();
        step();
        // real ack exactly at the limit wins
        set_m(0, 1, 1, 0, 32'h600, 32'h0);
        step();
        for (int k = 0; k < TO; k++) step();
        s_ack = 1'b1;
        s_dat = 32'hCAFEF00D;
        #1;
        chk("race_dat", m0_dat_o, 32'hCAFEF00D);
        chk("race_irq", 32'(to_irq), 32'd0);
        step();
        s_ack = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        step();
        step();
        // asynchronous reset in the middle of a master 1 burst
        set_m(1, 1, 1, 1, 32'h700, 32'h77);
        step();
        set_m(0, 1, 1, 0, 32'h800, 32'h0);
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        step();
        s_ack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cyc", 32'(s_cyc_o), 32'd0);
        chk("arst_stb", 32'(s_stb_o), 32'd0);
        chk("arst_grant", 32'(grant_o), 32'd0);
        chk("arst_ack", 32'(m1_ack_o), 32'd0);
        model_reset();
        s_ack = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("arst_tie", 32'(grant_o), 32'd1);
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        step();
        step();
        // random traffic against the model
        ackw = 4;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) ackw = int'($urandom_range(0, 8));
            for (int i = 0; i < 2; i++) begin
                if (!(mc[i] && $urandom_range(0, 7) != 0)) mc[i] = $urandom_range(0, 1) == 1;
                ms[i] = mc[i] ? $urandom_range(0, 3) != 0 : $urandom_range(0, 7) == 0;
                mw[i] = $urandom_range(0, 1) == 1;
                msel[i] = 4'($urandom);
                madr[i] = $urandom;
                mdat[i] = $urandom;
            end
            s_ack = int'($urandom_range(0, 15)) < ackw;
            s_dat = $urandom;
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
